// File: rtl/ws2812b_in_module.sv
// ws2812b_in_module
// Receiver/decoder for the WS2812B single-wire LED protocol. The line is
// synchronised, each high pulse is measured and turned into one bit (long
// pulse = 1, short pulse = 0), and bits are packed MSB first into BITS-wide
// words (G7..G0, R7..R0, B7..B0). A long low period marks the latch/frame end.
//
// Ports:
//   clk          system clock (9 MHz nominal)
//   reset        synchronous, active-high reset
//   ws2812b_data asynchronous serial input line
//   word         decoded word, stable while word_valid=1
//   word_valid   decoded word available
//   word_ready   consumer accepts word (transfer when word_valid & word_ready)
//   frame_end    one-cycle pulse when the latch low period is detected
//   error        one-cycle pulse on high-pulse timeout or partial word at latch
//   overflow     sticky, set when a completed word had to be dropped
//   debug_info   {state[1:0], synchronised line, overflow}
module ws2812b_in_module #(
  parameter int CYCLES_THRESHOLD = 4,
  parameter int CYCLES_RET       = 225,
  parameter int CYCLES_TIMEOUT   = 32,
  parameter int BITS             = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ws2812b_data,
  output logic [BITS-1:0] word,
  output logic            word_valid,
  input  logic            word_ready,
  output logic            frame_end,
  output logic            error,
  output logic            overflow,
  output logic [3:0]      debug_info
);

  localparam int LOW_W  = $clog2(CYCLES_RET + 1);
  localparam int HIGH_W = $clog2(CYCLES_TIMEOUT + 1);

  localparam logic [LOW_W-1:0]  LOW_RET   = LOW_W'(CYCLES_RET);
  localparam logic [LOW_W-1:0]  LOW_ONE   = LOW_W'(1);
  localparam logic [LOW_W-1:0]  LOW_ZERO  = LOW_W'(0);
  localparam logic [HIGH_W-1:0] HIGH_TO   = HIGH_W'(CYCLES_TIMEOUT);
  localparam logic [HIGH_W-1:0] HIGH_THR  = HIGH_W'(CYCLES_THRESHOLD);
  localparam logic [HIGH_W-1:0] HIGH_ONE  = HIGH_W'(1);
  localparam logic [HIGH_W-1:0] HIGH_ZERO = HIGH_W'(0);
  localparam logic [4:0]        BIT_LAST  = 5'(BITS - 1);
  localparam logic [4:0]        BIT_ONE   = 5'd1;
  localparam logic [4:0]        BIT_ZERO  = 5'd0;
  localparam logic [BITS-1:0]   WORD_ZERO = {BITS{1'b0}};

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Registers
  logic              s1_r;
  logic              s2_r;
  logic              s2_d_r;
  state_t            state_r;
  logic [LOW_W-1:0]  low_cnt_r;
  logic [HIGH_W-1:0] high_cnt_r;
  logic [4:0]        bit_cnt_r;
  logic [BITS-1:0]   shift_r;
  logic              done_r;
  logic [BITS-1:0]   word_r;
  logic              word_valid_r;
  logic              frame_end_r;
  logic              error_r;
  logic              overflow_r;

  // Next-state / pulse signals
  state_t            state_s;
  logic [LOW_W-1:0]  low_cnt_s;
  logic [HIGH_W-1:0] high_cnt_s;
  logic [4:0]        bit_cnt_s;
  logic [BITS-1:0]   shift_s;
  logic              done_s;
  logic              frame_end_s;
  logic              error_s;
  logic              rise_s;
  logic              fall_s;
  logic              bit_val_s;

  assign rise_s    = s2_r & ~s2_d_r;
  assign fall_s    = ~s2_r & s2_d_r;
  assign bit_val_s = (high_cnt_r >= HIGH_THR);

  // Two-flop synchroniser plus delayed copy of the second stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      s2_d_r <= 1'b0;
    end else begin
      s1_r   <= ws2812b_data;
      s2_r   <= s1_r;
      s2_d_r <= s2_r;
    end
  end

  // Decoder state, pulse-width counters and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_SYNC;
      low_cnt_r  <= LOW_ZERO;
      high_cnt_r <= HIGH_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= WORD_ZERO;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      low_cnt_r  <= low_cnt_s;
      high_cnt_r <= high_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      done_r     <= done_s;
    end
  end

  // Next-state logic: pulse measurement, bit decode, latch and timeout detection
  always_comb begin
    state_s     = state_r;
    low_cnt_s   = low_cnt_r;
    high_cnt_s  = high_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    done_s      = 1'b0;
    frame_end_s = 1'b0;
    error_s     = 1'b0;
    case (state_r)
      // Wait for a full latch-length low before trusting bit boundaries;
      // entering LOW this way is silent (no frame_end).
      ST_SYNC: begin
        if (s2_r) begin
          low_cnt_s = LOW_ZERO;
        end else if (low_cnt_r >= (LOW_RET - LOW_ONE)) begin
          low_cnt_s = LOW_RET;
          bit_cnt_s = BIT_ZERO;
          state_s   = ST_LOW;
        end else begin
          low_cnt_s = low_cnt_r + LOW_ONE;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          state_s    = ST_HIGH;
          high_cnt_s = HIGH_ONE;
          low_cnt_s  = LOW_ZERO;
        end else if (!s2_r && (low_cnt_r < LOW_RET)) begin
          low_cnt_s = low_cnt_r + LOW_ONE;
          // Saturation keeps this to one frame_end per low period.
          if (low_cnt_r == (LOW_RET - LOW_ONE)) begin
            frame_end_s = 1'b1;
            if (bit_cnt_r != BIT_ZERO) begin
              error_s   = 1'b1;
              bit_cnt_s = BIT_ZERO;
              shift_s   = WORD_ZERO;
            end else begin
              bit_cnt_s = bit_cnt_r;
            end
          end else begin
            frame_end_s = 1'b0;
          end
        end else begin
          low_cnt_s = low_cnt_r;
        end
      end
      ST_HIGH: begin
        if (fall_s) begin
          shift_s    = {shift_r[BITS-2:0], bit_val_s};
          state_s    = ST_LOW;
          low_cnt_s  = LOW_ONE;
          high_cnt_s = HIGH_ZERO;
          if (bit_cnt_r >= BIT_LAST) begin
            bit_cnt_s = BIT_ZERO;
            done_s    = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end
        end else if (s2_r) begin
          if (high_cnt_r >= (HIGH_TO - HIGH_ONE)) begin
            high_cnt_s = HIGH_TO;
            error_s    = 1'b1;
            bit_cnt_s  = BIT_ZERO;
            shift_s    = WORD_ZERO;
            low_cnt_s  = LOW_ZERO;
            state_s    = ST_SYNC;
          end else begin
            high_cnt_s = high_cnt_r + HIGH_ONE;
          end
        end else begin
          high_cnt_s = high_cnt_r;
        end
      end
      default: begin
        state_s    = ST_SYNC;
        low_cnt_s  = LOW_ZERO;
        high_cnt_s = HIGH_ZERO;
        bit_cnt_s  = BIT_ZERO;
        shift_s    = WORD_ZERO;
      end
    endcase
  end

  // Output stage: word handshake, overflow tracking and registered pulses.
  // shift_r is read one cycle after completion; it cannot change in that
  // cycle because the next shift needs a rising edge and a falling edge first.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r       <= WORD_ZERO;
      word_valid_r <= 1'b0;
      frame_end_r  <= 1'b0;
      error_r      <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      frame_end_r <= frame_end_s;
      error_r     <= error_s;
      if (done_r) begin
        if (!word_valid_r || word_ready) begin
          word_r       <= shift_r;
          word_valid_r <= 1'b1;
        end else begin
          overflow_r <= 1'b1;
        end
      end else if (word_valid_r && word_ready) begin
        word_valid_r <= 1'b0;
      end else begin
        word_valid_r <= word_valid_r;
      end
    end
  end

  assign word       = word_r;
  assign word_valid = word_valid_r;
  assign frame_end  = frame_end_r;
  assign error      = error_r;
  assign overflow   = overflow_r;
  assign debug_info = {state_r, s2_r, overflow_r};

endmodule

// File: tb/tb_ws2812b_in_module.sv
// Directed bench for ws2812b_in_module. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, so each sample shows the
// state left by the preceding edge. Edge numbers are counted in cyc_n.
module tb_ws2812b_in_module;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws2812b_data;
  logic [23:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        frame_end;
  logic        error;
  logic        overflow;
  logic [3:0]  debug_info;

  always #5 clk = ~clk;

  ws2812b_in_module dut (
    .clk          (clk),
    .reset        (reset),
    .ws2812b_data (ws2812b_data),
    .word         (word),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .frame_end    (frame_end),
    .error        (error),
    .overflow     (overflow),
    .debug_info   (debug_info)
  );

  int npass = 0;
  int ntot  = 0;
  int cyc_n = 0;
  int fall_edge = 0;
  int nvalid = 0;
  int v_stamp = -1;
  int nfe = 0;
  int fe_stamp = -1;
  int nerr = 0;
  int err_stamp = -1;
  int nfe0;
  int nerr0;
  int nbad;
  logic [23:0] got[$];
  logic [21:0] p22;
  logic [9:0]  p10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] got_at(input int i);
    if (i < got.size()) return got[i];
    else return 24'hxxxxxx;
  endfunction

  // One clock: drive the line, log what the DUT presents to this edge, step.
  task automatic cyc(input logic d);
    ws2812b_data = d;
    if (word_valid === 1'b1 && word_ready === 1'b1) got.push_back(word);
    if (word_valid === 1'b1) begin nvalid++; v_stamp = cyc_n; end
    if (frame_end === 1'b1) begin nfe++; fe_stamp = cyc_n; end
    if (error === 1'b1) begin nerr++; err_stamp = cyc_n; end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // High for h cycles then low for l; fall_edge = edge that first samples low.
  task automatic pulse(input int h, input int l);
    repeat (h) cyc(1'b1);
    fall_edge = cyc_n + 1;
    repeat (l) cyc(1'b0);
  endtask

  task automatic sbit(input logic b);
    if (b) pulse(5, 3);
    else   pulse(3, 5);
  endtask

  task automatic sword(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) sbit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ws2812b_data = 1'b0;
    word_ready = 1'b0;

    // ---- Test 1: reset state, first word and its latency ----
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
    chk("rst_word", word, 24'h000000);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_frame_end", frame_end, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_debug", debug_info, 4'h0);
    nvalid = 0; nfe = 0; nerr = 0;
    idle(230);
    chk("t1_debug_low", debug_info, 4'b0100);
    word_ready = 1'b1;
    sword(24'hFF00A5);
    idle(10);
    chk("t1_count", got.size(), 1);
    chk("t1_word", got_at(0), 24'hFF00A5);
    chk("t1_valid_cycles", nvalid, 1);
    chk("t1_latency", v_stamp, fall_edge + 3);
    chk("t1_no_error", nerr, 0);
    chk("t1_no_frame_end", nfe, 0);

    // ---- Test 2: 36 back-to-back words then latch ----
    got.delete();
    nvalid = 0;
    for (int w = 1; w <= 36; w++) sword(24'(w));
    idle(450);
    chk("t2_count", got.size(), 36);
    nbad = 0;
    for (int i = 0; i < 36; i++) if (got_at(i) !== 24'(i + 1)) nbad++;
    chk("t2_words_in_order", nbad, 0);
    chk("t2_valid_cycles", nvalid, 36);
    chk("t2_frame_end_count", nfe, 1);
    chk("t2_frame_end_time", fe_stamp, fall_edge + 226);
    chk("t2_no_error", nerr, 0);
    chk("t2_overflow", overflow, 1'b0);

    // ---- Test 3: threshold and timeout boundaries ----
    got.delete();
    pulse(3, 4);
    pulse(4, 4);
    p22 = 22'h155555;
    for (int i = 21; i >= 0; i--) sbit(p22[i]);
    idle(10);
    chk("t3_h3_h4", got_at(0), 24'h555555);
    pulse(31, 4);
    for (int i = 0; i < 23; i++) sbit(1'b0);
    idle(10);
    chk("t3_h31", got_at(1), 24'h800000);
    nerr0 = nerr;
    pulse(32, 4);
    chk("t3_h32_error", nerr, nerr0 + 1);
    chk("t3_h32_error_time", err_stamp, fall_edge + 1);
    sword(24'h0F0F0F);
    chk("t3_sync_no_decode", got.size(), 2);
    nfe0 = nfe;
    idle(230);
    chk("t3_sync_no_frame_end", nfe, nfe0);
    sword(24'h0F0F0F);
    idle(230);
    chk("t3_resync_word", got_at(2), 24'h0F0F0F);
    chk("t3_resync_frame_end", nfe, nfe0 + 1);
    chk("t3_error_total", nerr, nerr0 + 1);

    // ---- Test 4: backpressure and overflow ----
    got.delete();
    word_ready = 1'b0;
    sword(24'h123456);
    sword(24'hABCDEF);
    idle(10);
    chk("t4_held_valid", word_valid, 1'b1);
    chk("t4_held_word", word, 24'h123456);
    chk("t4_overflow", overflow, 1'b1);
    word_ready = 1'b1;
    cyc(1'b0);
    chk("t4_valid_dropped", word_valid, 1'b0);
    chk("t4_one_transfer", got.size(), 1);
    chk("t4_transfer_word", got_at(0), 24'h123456);
    chk("t4_overflow_sticky", overflow, 1'b1);

    // ---- Test 5: partial word at latch ----
    got.delete();
    nfe0 = nfe;
    nerr0 = nerr;
    p10 = 10'h2AA;
    for (int i = 9; i >= 0; i--) sbit(p10[i]);
    idle(230);
    chk("t5_frame_end", nfe, nfe0 + 1);
    chk("t5_error", nerr, nerr0 + 1);
    chk("t5_same_cycle", err_stamp, fe_stamp);
    chk("t5_frame_end_time", fe_stamp, fall_edge + 226);
    chk("t5_no_word", got.size(), 0);
    sword(24'hC3C3C3);
    idle(10);
    chk("t5_next_word", got_at(0), 24'hC3C3C3);

    // ---- Test 6: mid-frame start after reset, reset during a word ----
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    got.delete();
    nfe0 = nfe;
    sword(24'h5A5A5A);
    idle(230);
    chk("t6_midframe_ignored", got.size(), 0);
    chk("t6_no_frame_end", nfe, nfe0);
    chk("t6_debug_low", debug_info, 4'b0100);
    word_ready = 1'b0;
    sword(24'h5A5A5A);
    idle(5);
    chk("t6_pending_word", word, 24'h5A5A5A);
    chk("t6_pending_valid", word_valid, 1'b1);
    for (int i = 0; i < 11; i++) sbit(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    reset = 1'b1;
    cyc(1'b1);
    chk("t6_rst_word", word, 24'h000000);
    chk("t6_rst_valid", word_valid, 1'b0);
    chk("t6_rst_frame_end", frame_end, 1'b0);
    chk("t6_rst_error", error, 1'b0);
    chk("t6_rst_overflow", overflow, 1'b0);
    chk("t6_rst_debug", debug_info, 4'h0);
    reset = 1'b0;
    idle(5);
    chk("t6_after_rst_valid", word_valid, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ws2812b_in_module.md
Name: ws2812b_in_module

Overview:
- Receiver/decoder for the WS2812B single-wire LED protocol; counterpart of the existing WS2812B output module.
- Samples a ws2812b data line, measures each high-pulse width, and decodes the stream into 24-bit words, MSB first (G7..G0, R7..R0, B7..B0).
- Detects the latch/return-to-zero low period.
- Used for loopback self-test of the LED driver chain on the board and for accepting pixel data from an upstream WS2812B source.

Parameters:
- CYCLES_THRESHOLD, 4: high pulse of at least this many clk cycles decodes as 1; shorter decodes as 0 (9 MHz: short=3, long=5).
- CYCLES_RET, 225: continuous low cycles that mark latch/frame end (25 us at 9 MHz).
- CYCLES_TIMEOUT, 32: high pulse reaching this length is a line error.
- BITS, 24: bits per word.

Ports:
- clk, input, 1: system clock (PLL clock, 9 MHz nominal).
- reset, input, 1: synchronous, active-high reset.
- ws2812b_data, input, 1: asynchronous serial line.
- word, output, BITS: decoded word, stable while word_valid=1.
- word_valid, output, 1: decoded word available.
- word_ready, input, 1: consumer accepts word.
- frame_end, output, 1: one-cycle pulse on latch detection.
- error, output, 1: one-cycle pulse on timeout or partial word.
- overflow, output, 1: sticky; set when a word is dropped.
- debug_info, output, 4: {state[1:0], synced line, overflow}.

Behaviour:
- **Input synchroniser:** 2-flop sync on ws2812b_data; all pulse measurement uses the 2nd stage (s2). Edges are detected as s2 vs its delayed copy.
- **Reset:** while reset=1 at a clk edge:
  - state=SYNC; all counters 0; shift register 0.
  - word=0; word_valid=0; frame_end=0; error=0; overflow=0; debug_info=0.
  - Reset mid-word discards the partial word and any pending word.
- **SYNC:**
  - low_cnt counts while s2=0 and clears on s2=1.
  - At low_cnt==CYCLES_RET: go LOW (low_cnt saturated, bit_cnt=0). No frame_end is generated.
  - Prevents decoding from mid-stream after reset or error.
- **LOW:**
  - low_cnt increments, saturating at CYCLES_RET.
  - On reaching CYCLES_RET (once per low period), pulse frame_end.
  - If bit_cnt!=0 at that point, pulse error in the same cycle, discard the partial word, and set bit_cnt=0.
  - Rising edge of s2: go HIGH, with high_cnt=1 and low_cnt=0.
- **HIGH:**
  - high_cnt increments.
  - Falling edge of s2: bit = (high_cnt >= CYCLES_THRESHOLD). Shift it into the LSB of the shift register (MSB first overall), bit_cnt+1, go LOW with low_cnt=1.
  - When the 24th bit is decoded: bit_cnt=0; shift register is presented to word.
  - high_cnt reaching CYCLES_TIMEOUT: pulse error, bit_cnt=0, go SYNC.
- **Latency:** word_valid rises on the 3rd rising clk edge after the first edge at which ws2812b_data is sampled low at the end of the 24th bit.
- **Handshake:**
  - Transfer occurs at an edge with word_valid=1 and word_ready=1; word_valid then drops unless a new word completes at the same edge.
  - New word completes while word_valid=0, or word_valid=1 with word_ready=1: load word, word_valid=1 (back-to-back accepted, no gap).
  - New word completes while word_valid=1 with word_ready=0: new word dropped, old word held, overflow set (sticky until reset).
  - word_ready while word_valid=0 is ignored.
- **Simultaneous events:** frame_end and a word completion cannot coincide (a completion occurs on a falling edge, frame_end ≥ CYCLES_RET-1 cycles later). Error and frame_end may coincide (partial word).
- **Widths:**
  - low_cnt is clog2(CYCLES_RET+1) bits; high_cnt is clog2(CYCLES_TIMEOUT+1) bits; bit_cnt is 5 bits.
  - Counters saturate; they never wrap.

Test Plan:
1. Reset; line low 225 cycles; send 0xFF00A5 (1=5-cycle high/3-cycle low, 0=3-cycle high/5-cycle low); word_ready=1 -> word=0xFF00A5, word_valid high exactly 1 cycle, 3 edges after the last falling edge; no error.
2. Send 36 words {0x000001, 0x000002, …}, then low 450 cycles -> 36 valid words in order; exactly one frame_end, 225 cycles into the low; error=0; overflow=0.
3. Threshold boundary: bits with high=3 and high=4 cycles (low=4) -> decoded 0 and 1 respectively; repeat with high=31 -> 1, high=32 -> error, then no decode until 225 low cycles are seen.
4. word_ready=0; send 0x123456 then 0xABCDEF -> word stays 0x123456, word_valid=1, overflow=1; raise word_ready -> word_valid drops after one transfer; overflow stays 1.
5. Send 10 bits, then low 225 cycles -> frame_end and error pulse in the same cycle; no word_valid; next full word decodes correctly.
6. Start mid-frame after reset (no 225-cycle low first) -> bits ignored until the first 225-cycle low, with no frame_end for that low; assert reset during the 12th bit -> all outputs 0, state SYNC.
